// File: rtl/exp_alu_sequencer.sv
// Purpose : sequences an external combinational add/sub ALU to form the biased
//           product exponent (ea + eb - BIAS [+1]) with overflow/underflow clamp.
// Latency : start -> done 4 cycles, 5 with norm_inc, 1 for the zero bypass.
// Backpr. : none; start_in is ignored while busy_out=1 (including the DONE cycle).
//
// Ports
//   clk_in, rst_n_in          clock (rising edge), async active-low reset
//   start_in                  start request, only looked at in IDLE
//   exp_a_in, exp_b_in        biased operand exponents
//   norm_inc_in, zero_in      normalization +1 / operand-is-zero, captured with start
//   alu_A_out, alu_B_out,     operands and op (0 add, 1 A-B) for the shared ALU
//   alu_op_out
//   alu_result_in, alu_Z_in,  ALU result and zero/negative flags
//   alu_N_in
//   busy_out, done_out        busy outside IDLE; one-cycle done pulse
//   exp_out, ovf_out, unf_out result exponent and clamp flags, held until next start
module exp_alu_sequencer #(
  parameter int EXP_W = 5,
  parameter int BIAS  = 15,
  parameter int ALU_W = EXP_W + 2
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [EXP_W-1:0] exp_a_in,
  input  logic [EXP_W-1:0] exp_b_in,
  input  logic             norm_inc_in,
  input  logic             zero_in,
  output logic [ALU_W-1:0] alu_A_out,
  output logic [ALU_W-1:0] alu_B_out,
  output logic             alu_op_out,
  input  logic [ALU_W-1:0] alu_result_in,
  input  logic             alu_Z_in,
  input  logic             alu_N_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [EXP_W-1:0] exp_out,
  output logic             ovf_out,
  output logic             unf_out
);

  localparam logic [ALU_W-1:0] BIAS_W  = ALU_W'(BIAS);
  localparam logic [ALU_W-1:0] ONE_W   = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALL1_W  = {{(ALU_W-EXP_W){1'b0}}, {EXP_W{1'b1}}};
  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADD_E    = 3'd1,
    SUB_BIAS = 3'd2,
    INC      = 3'd3,
    CHK_OVF  = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [ALU_W-1:0] acc;
  logic             le0;      // exponent after bias/inc is <= 0
  logic [EXP_W-1:0] exp_a_q;
  logic [EXP_W-1:0] exp_b_q;
  logic             inc_q;

  // Next state plus ALU drive; ALU ports decode only registered state so the
  // combinational ALU path starts from flops every cycle.
  always_comb begin
    state_nxt  = state;
    alu_A_out  = '0;
    alu_B_out  = '0;
    alu_op_out = 1'b0;
    case (state)
      IDLE: begin
        if (start_in) state_nxt = zero_in ? DONE : ADD_E;
      end
      ADD_E: begin
        alu_A_out = ALU_W'(exp_a_q);
        alu_B_out = ALU_W'(exp_b_q);
        state_nxt = SUB_BIAS;
      end
      SUB_BIAS: begin
        alu_A_out  = acc;
        alu_B_out  = BIAS_W;
        alu_op_out = 1'b1;
        state_nxt  = inc_q ? INC : CHK_OVF;
      end
      INC: begin
        alu_A_out = acc;
        alu_B_out = ONE_W;
        state_nxt = CHK_OVF;
      end
      CHK_OVF: begin
        // acc - all_ones: a non-negative result means acc has reached the
        // reserved all-ones exponent or beyond.
        alu_A_out  = acc;
        alu_B_out  = ALL1_W;
        alu_op_out = 1'b1;
        state_nxt  = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state   <= IDLE;
      acc     <= '0;
      le0     <= 1'b0;
      exp_a_q <= '0;
      exp_b_q <= '0;
      inc_q   <= 1'b0;
      exp_out <= '0;
      ovf_out <= 1'b0;
      unf_out <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start_in) begin
            exp_a_q <= exp_a_in;
            exp_b_q <= exp_b_in;
            inc_q   <= norm_inc_in;
            le0     <= 1'b0;
            ovf_out <= 1'b0;
            unf_out <= 1'b0;
            // Zero operand: result is a clean zero exponent without flags.
            if (zero_in) exp_out <= '0;
          end
        end
        ADD_E: begin
          acc <= alu_result_in;
        end
        SUB_BIAS, INC: begin
          acc <= alu_result_in;
          le0 <= alu_N_in | alu_Z_in;
        end
        CHK_OVF: begin
          if (le0) begin
            unf_out <= 1'b1;
            exp_out <= '0;
          end else if (!alu_N_in) begin
            ovf_out <= 1'b1;
            exp_out <= EXP_MAX;
          end else begin
            exp_out <= acc[EXP_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_out = (state != IDLE);
  assign done_out = (state == DONE);

endmodule

// File: tb/tb_exp_alu_sequencer.sv
module tb_exp_alu_sequencer;

  localparam int EXP_W = 5;
  localparam int BIAS  = 15;
  localparam int ALU_W = EXP_W + 2;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic             start_in;
  logic [EXP_W-1:0] exp_a_in;
  logic [EXP_W-1:0] exp_b_in;
  logic             norm_inc_in;
  logic             zero_in;
  logic [ALU_W-1:0] alu_A_out;
  logic [ALU_W-1:0] alu_B_out;
  logic             alu_op_out;
  logic [ALU_W-1:0] alu_result_in;
  logic             alu_Z_in;
  logic             alu_N_in;
  logic             busy_out;
  logic             done_out;
  logic [EXP_W-1:0] exp_out;
  logic             ovf_out;
  logic             unf_out;

  int errors = 0;
  int checks = 0;

  exp_alu_sequencer #(.EXP_W(EXP_W), .BIAS(BIAS), .ALU_W(ALU_W)) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .start_in     (start_in),
    .exp_a_in     (exp_a_in),
    .exp_b_in     (exp_b_in),
    .norm_inc_in  (norm_inc_in),
    .zero_in      (zero_in),
    .alu_A_out    (alu_A_out),
    .alu_B_out    (alu_B_out),
    .alu_op_out   (alu_op_out),
    .alu_result_in(alu_result_in),
    .alu_Z_in     (alu_Z_in),
    .alu_N_in     (alu_N_in),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .exp_out      (exp_out),
    .ovf_out      (ovf_out),
    .unf_out      (unf_out)
  );

  always #5 clk_in = ~clk_in;

  // External combinational add/sub ALU.
  always_comb begin
    alu_result_in = alu_op_out ? (alu_A_out - alu_B_out) : (alu_A_out + alu_B_out);
    alu_Z_in      = (alu_result_in == '0);
    alu_N_in      = alu_result_in[ALU_W-1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Launch one operation; lat counts negedges after the accepting edge until
  // done_out is seen (1 = done in the first cycle after acceptance).
  task automatic run_op(input int a, input int b, input bit inc, input bit z,
                        output int lat, output logic [ALU_W-1:0] a1,
                        output logic [ALU_W-1:0] b1);
    @(negedge clk_in);
    exp_a_in    = EXP_W'(a);
    exp_b_in    = EXP_W'(b);
    norm_inc_in = inc;
    zero_in     = z;
    start_in    = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    lat = 1;
    a1  = alu_A_out;
    b1  = alu_B_out;
    while (!done_out && lat < 20) begin
      @(negedge clk_in);
      lat++;
    end
  endtask

  initial begin
    int               lat;
    int               dones;
    logic [ALU_W-1:0] a1, b1;

    rst_n_in    = 1'b0;
    start_in    = 1'b0;
    exp_a_in    = '0;
    exp_b_in    = '0;
    norm_inc_in = 1'b0;
    zero_in     = 1'b0;
    repeat (2) @(negedge clk_in);

    // Reset state
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_exp", exp_out, 0);
    chk("rst_ovf", ovf_out, 0);
    chk("rst_unf", unf_out, 0);
    chk("rst_aluA", alu_A_out, 0);
    chk("rst_aluB", alu_B_out, 0);
    chk("rst_aluop", alu_op_out, 0);
    rst_n_in = 1'b1;

    // Normal path: 16+17-15 = 18
    run_op(16, 17, 0, 0, lat, a1, b1);
    chk("norm_lat", lat, 4);
    chk("norm_exp", exp_out, 18);
    chk("norm_ovf", ovf_out, 0);
    chk("norm_unf", unf_out, 0);
    chk("norm_addA", a1, 16);
    chk("norm_addB", b1, 17);

    // Reset during SUB_BIAS
    @(negedge clk_in);
    exp_a_in = 5'd30; exp_b_in = 5'd30; norm_inc_in = 1'b0; zero_in = 1'b0;
    start_in = 1'b1;
    @(negedge clk_in);            // ADD_E
    start_in = 1'b0;
    @(negedge clk_in);            // SUB_BIAS
    chk("mid_busy_pre", busy_out, 1);
    chk("mid_aluA_pre", alu_A_out, 60);
    rst_n_in = 1'b0;
    #1;
    chk("mid_busy", busy_out, 0);
    chk("mid_exp", exp_out, 0);
    chk("mid_aluA", alu_A_out, 0);
    chk("mid_aluop", alu_op_out, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_in);
      if (done_out) dones++;
    end
    chk("mid_no_done", dones, 0);

    // Normal operation after reset
    run_op(16, 17, 0, 0, lat, a1, b1);
    chk("post_lat", lat, 4);
    chk("post_exp", exp_out, 18);

    // Overflow: 60-15 = 45
    run_op(30, 30, 0, 0, lat, a1, b1);
    chk("ovf_exp", exp_out, 31);
    chk("ovf_flag", ovf_out, 1);
    chk("ovf_unf", unf_out, 0);

    // Overflow boundary with increment: 45-15+1 = 31
    run_op(23, 22, 1, 0, lat, a1, b1);
    chk("ovfb_lat", lat, 5);
    chk("ovfb_exp", exp_out, 31);
    chk("ovfb_flag", ovf_out, 1);

    // Underflow: 11-15 = -4
    run_op(5, 6, 0, 0, lat, a1, b1);
    chk("unf_exp", exp_out, 0);
    chk("unf_flag", unf_out, 1);
    chk("unf_ovf", ovf_out, 0);

    // Underflow boundary: result exactly 0
    run_op(8, 7, 0, 0, lat, a1, b1);
    chk("unf0_exp", exp_out, 0);
    chk("unf0_flag", unf_out, 1);

    // Increment lifts zero to 1
    run_op(8, 7, 1, 0, lat, a1, b1);
    chk("inc1_lat", lat, 5);
    chk("inc1_exp", exp_out, 1);
    chk("inc1_unf", unf_out, 0);
    chk("inc1_ovf", ovf_out, 0);

    // Zero bypass
    run_op(20, 20, 0, 1, lat, a1, b1);
    chk("zero_lat", lat, 1);
    chk("zero_exp", exp_out, 0);
    chk("zero_ovf", ovf_out, 0);
    chk("zero_unf", unf_out, 0);
    chk("zero_aluA", a1, 0);
    chk("zero_aluB", b1, 0);
    chk("zero_aluop", alu_op_out, 0);

    // Busy protocol: start held high through DONE must be ignored
    @(negedge clk_in);
    exp_a_in = 5'd16; exp_b_in = 5'd17; norm_inc_in = 1'b0; zero_in = 1'b0;
    start_in = 1'b1;
    dones = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_in);
      if (k == 1) begin
        chk("busy_rise", busy_out, 1);
        zero_in  = 1'b1;
        exp_a_in = 5'd3;
      end
      if (done_out) dones++;
      if (k == 5) begin
        chk("busy_drop_start", busy_out, 0);
        start_in = 1'b0;
      end
    end
    chk("busy_one_done", dones, 1);
    chk("busy_exp", exp_out, 18);

    // Result held while idle
    repeat (5) @(negedge clk_in);
    chk("hold_exp", exp_out, 18);
    chk("hold_done", done_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
